safe_lockout_ctrl: RTL

Access sequencer between `password_manager`'s compare result and the safe's status outputs (`vga_status`, `led6_r`/`led6_g`). It gates the user's `ok` request and counts consecutive wrong entries. After `MAX_FAIL` failures it enforces a timed lockout with a seconds countdown, and it grants password-change permission only while the safe is open. It runs on the 25.2 MHz pixel clock domain shared with `pattern_gen`.

---
 rtl/safe_lockout_ctrl_pkg.sv | 14 +
 rtl/safe_lockout_ctrl_if.sv | 22 ++
 rtl/safe_lockout_ctrl_sec_tick_gen.sv | 25 ++
 rtl/safe_lockout_ctrl.sv | 87 ++++++++
 4 files changed

// File: rtl/safe_lockout_ctrl_pkg.sv
// safe_pkg: state/status codes and clock default shared by the safe controller and pattern_gen
package safe_pkg;
  localparam int CLK_HZ_DEF = 25_200_000;
  localparam logic [1:0] ST_ARMED   = 2'd0;
  localparam logic [1:0] ST_OPEN    = 2'd1;
  localparam logic [1:0] ST_FAIL    = 2'd2;
  localparam logic [1:0] ST_LOCKOUT = 2'd3;
  typedef enum logic [1:0] {
    ARMED   = ST_ARMED,
    OPEN    = ST_OPEN,
    FAIL    = ST_FAIL,
    LOCKOUT = ST_LOCKOUT
  } state_t;
endpackage

// File: rtl/safe_lockout_ctrl_if.sv
// safe_lockout_ctrl_if: request inputs and status outputs of the lockout controller
interface safe_lockout_ctrl_if;
  logic       ok_in;
  logic       check_valid;
  logic       check_pass;
  logic       relock;
  logic       ok_out;
  logic       set_allow;
  logic [2:0] fail_cnt;
  logic [7:0] lock_remain;
  logic [1:0] vga_status;
  logic       led6_r;
  logic       led6_g;
  modport master (
    output ok_in, check_valid, check_pass, relock,
    input  ok_out, set_allow, fail_cnt, lock_remain, vga_status, led6_r, led6_g
  );
  modport slave (
    input  ok_in, check_valid, check_pass, relock,
    output ok_out, set_allow, fail_cnt, lock_remain, vga_status, led6_r, led6_g
  );
endinterface

// File: rtl/safe_lockout_ctrl_sec_tick_gen.sv
// sec_tick_gen: clearable one-second prescaler with wrap pulse and next-cycle half-period flag
module sec_tick_gen
  import safe_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEF,
  parameter int W      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_run,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap,
  output logic         o_half_nxt
);
  logic [W-1:0] r_cnt;
  logic [W-1:0] w_nxt;
  assign o_wrap     = i_run && r_cnt == W'(CLK_HZ - 1);
  assign w_nxt      = (i_clr || o_wrap) ? '0 : i_run ? r_cnt + W'(1) : r_cnt;
  // look-ahead so the blink LED can be registered alongside the state
  assign o_half_nxt = w_nxt < W'(CLK_HZ / 2);
  assign o_cnt      = r_cnt;
  always_ff @(posedge clk)
    r_cnt <= rst ? '0 : w_nxt;
endmodule

// File: rtl/safe_lockout_ctrl.sv
// safe_lockout_ctrl: access FSM gating ok, counting wrong entries and enforcing a timed lockout
module safe_lockout_ctrl
  import safe_pkg::*;
#(
  parameter int CLK_HZ    = CLK_HZ_DEF,
  parameter int MAX_FAIL  = 3,
  parameter int FAIL_HOLD = 25_200_000,
  parameter int LOCK_SEC  = 10
) (
  input logic                 clk,
  input logic                 rst,
  safe_lockout_ctrl_if.slave  bus
);
  localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  state_t       r_state, w_state;
  logic [2:0]   r_fail, w_fail;
  logic [7:0]   r_rem, w_rem;
  logic         r_ok, r_set, r_led_r, r_led_g;
  logic [W-1:0] w_cnt;
  logic         w_wrap, w_half, w_clr, w_run;
  assign w_run = r_state == FAIL || r_state == LOCKOUT;
  assign w_clr = w_state != r_state;
  sec_tick_gen #(.CLK_HZ(CLK_HZ), .W(W)) u_tick (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_clr),
    .i_run      (w_run),
    .o_cnt      (w_cnt),
    .o_wrap     (w_wrap),
    .o_half_nxt (w_half)
  );
  always_comb begin
    w_state = r_state;
    w_fail  = r_fail;
    w_rem   = r_rem;
    case (r_state)
      ARMED:
        if (bus.check_valid) begin
          if (bus.check_pass) begin
            w_state = OPEN;
            w_fail  = '0;
          end else if (r_fail + 3'd1 == 3'(MAX_FAIL)) begin
            w_state = LOCKOUT;
            w_fail  = '0;
            w_rem   = 8'(LOCK_SEC);
          end else begin
            w_state = FAIL;
            w_fail  = r_fail + 3'd1;
          end
        end
      OPEN:    w_state = bus.relock ? ARMED : OPEN;
      FAIL:    w_state = (w_cnt == W'(FAIL_HOLD - 1)) ? ARMED : FAIL;
      LOCKOUT:
        if (w_wrap) begin
          w_rem   = r_rem - 8'd1;
          w_state = (r_rem == 8'd1) ? ARMED : LOCKOUT;
        end
      default: w_state = ARMED;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARMED;
      r_fail  <= '0;
      r_rem   <= '0;
      r_ok    <= 1'b0;
      r_set   <= 1'b0;
      r_led_r <= 1'b0;
      r_led_g <= 1'b0;
    end else begin
      r_state <= w_state;
      r_fail  <= w_fail;
      r_rem   <= w_rem;
      r_ok    <= bus.ok_in && r_state == ARMED;
      r_set   <= w_state == OPEN;
      r_led_g <= w_state == OPEN;
      r_led_r <= w_state == FAIL || (w_state == LOCKOUT && w_half);
    end
  end
  assign bus.ok_out      = r_ok;
  assign bus.set_allow   = r_set;
  assign bus.fail_cnt    = r_fail;
  assign bus.lock_remain = r_rem;
  assign bus.vga_status  = r_state;
  assign bus.led6_r      = r_led_r;
  assign bus.led6_g      = r_led_g;
endmodule
